pipe_stage_hs: RTL and testbench
================================

Name: pipe_stage_hs

Overview:
- Parametrised, handshaked pipeline register for the processor datapath. It is the general successor of the fixed fetch/decode latch.
- Carries an arbitrary-width payload between stages using a valid/ready handshake. Supports back-pressure (stall) and synchronous flush, which replaces the zero-on-reset bubble trick.
- Optional skid buffer registers `in_ready`, breaking the combinational ready path across stages.
- Instantiated once per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 96, payload width in bits (default = instr + PC + PC+4).
- SKID, 1, 1 = two-entry skid buffer with registered `in_ready`; 0 = single register, combinational `in_ready`.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- flush  in  1  synchronous flush; discards all held entries.
- in_valid  in  1  upstream presents payload.
- in_ready  out  1  stage can accept payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage holds valid payload for downstream.
- out_ready  in  1  downstream accepts payload this cycle.
- out_data  out  DATA_W  payload to downstream.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (reset=0, async): main/skid valids = 0; main/skid data = 0; stall_cnt = 0; out_valid = 0; out_data = 0; in_ready = 1.
- Latency 1 cycle: data accepted at edge N appears on out_data after edge N. Throughput 1 per cycle when out_ready=1.
- out_data/out_valid are driven directly from the main register, never from in_data combinationally.
- SKID=1 state machine; state is encoded by (main_v, skid_v); in_ready = ~skid_v, registered.
  - EMPTY (0,0): in_fire -> main<=in_data, go to FULL.
  - FULL (1,0):
    - in_fire & out_fire -> main<=in_data, stay in FULL.
    - in_fire & ~out_fire -> skid<=in_data, go to SKID.
    - ~in_fire & out_fire -> go to EMPTY.
    - otherwise hold.
  - SKID (1,1): in_ready = 0.
    - out_fire -> main<=skid, skid_v<=0, go to FULL.
    - otherwise hold.
  - Ordering: entries leave in arrival order; no payload is ever duplicated or dropped except by flush.
- SKID=0: in_ready = ~main_v | out_ready (combinational). in_fire loads main; ~in_fire & out_fire clears main_v. The skid register is not instantiated.
- flush=1 (highest priority after reset):
  - At the next edge both valids go to 0 and both data registers go to 0.
  - An in_fire in the same cycle is discarded; the upstream handshake still completes.
  - out_fire in the flush cycle is honoured by downstream, since the payload was presented.
  - State after flush = EMPTY; in_ready = 1 the following cycle.
- stall_cnt:
  - Increments each edge where out_valid & ~out_ready.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Unaffected by flush; cleared only by reset.
- Reset asserted mid-transfer: immediate return to reset values. Held payloads are lost; upstream is not notified.
- While out_valid=1 & out_ready=0, out_data is held stable. This is a protocol guarantee to downstream.
- in_data is don't-care when in_valid=0; it must not affect state.

Decomposition:
- Shared package pipe_pkg: default DATA_W constant and the stage-payload field widths/offsets (INSTR_W=32, PC_W=32). Each stage's payload layout lives there so ID/EX and later stages reuse it.
- Optional sub-module pipe_cnt_sat (saturating counter, parameter CNT_W) for stall_cnt, reusable for other performance counters.
- The skid logic stays inline, selected by a generate on SKID.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, then release.
  - During and after reset: out_valid=0, out_data=0, in_ready=1, stall_cnt=0.
- Streaming: out_ready=1; send 0x01..0x08 on consecutive cycles.
  - out_data = 0x01..0x08 each one cycle later, with no bubbles.
  - Required for both SKID=1 and SKID=0.
- Back-pressure (SKID=1): stream 0xA0, 0xA1, 0xA2; drop out_ready for 3 cycles once 0xA0 is presented.
  - 0xA1 is captured in skid and in_ready falls to 0.
  - 0xA2 is held upstream.
  - After out_ready=1, output order is 0xA0, 0xA1, 0xA2.
  - stall_cnt = 3.
- Flush in SKID state: reach (1,1) holding 0xB0/0xB1, then pulse flush with in_valid=1, in_data=0xB2.
  - Next cycle: out_valid=0, in_ready=1.
  - 0xB2 never appears on out_data.
- Saturation: CNT_W=4; hold out_valid=1, out_ready=0 for 20 cycles.
  - stall_cnt reaches 15 and stays at 15.
  - A following flush leaves it at 15.
- Async reset mid-stall: assert reset=0 between clock edges while in SKID.
  - Outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared payload layout and handshake state encoding for pipeline stage registers
package pipe_pkg;

    localparam int INSTR_W     = 32;
    localparam int PC_W        = 32;
    localparam int PIPE_DATA_W = INSTR_W + 2 * PC_W;

    localparam int INSTR_LSB = 0;
    localparam int PC_LSB    = INSTR_LSB + INSTR_W;
    localparam int PC4_LSB   = PC_LSB + PC_W;

    typedef struct packed {
        logic [PC_W-1:0]    pc4;
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } if_id_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b10,
        ST_SKID  = 2'b11
    } hs_state_e;

endpackage

// File: rtl/pipe_cnt_sat.sv
// pipe_cnt_sat: saturating event counter, cleared only by reset
module pipe_cnt_sat #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // count up on inc, sticking at all-ones
    always_comb cnt_d = (inc && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

    // counter register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: valid/ready pipeline register with optional skid buffer, flush and stall counter
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    if (SKID != 0) begin : g_skid
        hs_state_e         state_q, state_d;
        logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
        logic              in_fire, out_fire;

        assign in_ready  = ~state_q[0];
        assign out_valid = state_q[1];
        assign out_data  = main_q;
        assign in_fire   = in_valid & in_ready;
        assign out_fire  = out_valid & out_ready;

        // next state: flush empties both entries, otherwise skid-buffer transitions
        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            if (flush) begin
                state_d = ST_EMPTY;
                main_d  = '0;
                skid_d  = '0;
            end else begin
                case (state_q)
                    ST_EMPTY: if (in_fire) begin
                        main_d  = in_data;
                        state_d = ST_FULL;
                    end
                    ST_FULL: if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = ST_SKID;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                    ST_SKID: if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ST_FULL;
                    end
                    default: state_d = ST_EMPTY;
                endcase
            end
        end

        // state and payload registers
        always_ff @(posedge clk or negedge reset)
            if (!reset) begin
                state_q <= ST_EMPTY;
                main_q  <= '0;
                skid_q  <= '0;
            end else begin
                state_q <= state_d;
                main_q  <= main_d;
                skid_q  <= skid_d;
            end
    end else begin : g_single
        logic              main_v_q, main_v_d;
        logic [DATA_W-1:0] main_q, main_d;
        logic              in_fire, out_fire;

        assign in_ready  = ~main_v_q | out_ready;
        assign out_valid = main_v_q;
        assign out_data  = main_q;
        assign in_fire   = in_valid & in_ready;
        assign out_fire  = out_valid & out_ready;

        // single entry: load on accept, drain on departure, clear on flush
        always_comb begin
            main_v_d = main_v_q;
            main_d   = main_q;
            if (flush) begin
                main_v_d = 1'b0;
                main_d   = '0;
            end else if (in_fire) begin
                main_v_d = 1'b1;
                main_d   = in_data;
            end else if (out_fire) begin
                main_v_d = 1'b0;
            end
        end

        // valid and payload register
        always_ff @(posedge clk or negedge reset)
            if (!reset) begin
                main_v_q <= 1'b0;
                main_q   <= '0;
            end else begin
                main_v_q <= main_v_d;
                main_q   <= main_d;
            end
    end

    pipe_cnt_sat #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (out_valid & ~out_ready),
        .cnt   (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: scoreboard bench for skid, single-register and narrow-counter stage variants
module tb_pipe_stage_hs;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [95:0] in_data;
    logic        ir[3];
    logic        ov[3];
    logic [95:0] od[3];
    logic [15:0] sc_a, sc_b;
    logic [3:0]  sc_c;
    logic [95:0] sb[3][$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    pipe_stage_hs #(.SKID(1)) u_a (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .stall_cnt(sc_a)
    );
    pipe_stage_hs #(.SKID(0)) u_b (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .stall_cnt(sc_b)
    );
    pipe_stage_hs #(.SKID(1), .CNT_W(4)) u_c (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
        .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .stall_cnt(sc_c)
    );

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [95:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    task automatic check_idle(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_out_valid%0d", tag, k), 96'(ov[k]), 96'd0);
            check($sformatf("%s_out_data%0d", tag, k), od[k], 96'd0);
            check($sformatf("%s_in_ready%0d", tag, k), 96'(ir[k]), 96'd1);
        end
        check({tag, "_stall_a"}, 96'(sc_a), 96'd0);
        check({tag, "_stall_b"}, 96'(sc_b), 96'd0);
        check({tag, "_stall_c"}, 96'(sc_c), 96'd0);
    endtask

    // scoreboard: retire on out_fire, record on in_fire, discard everything on flush
    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 3; k++) sb[k].delete();
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (ov[k] && out_ready) begin
                    if (sb[k].size() == 0) check($sformatf("sb_spurious%0d", k), 96'(sb[k].size()), 96'd1);
                    else check($sformatf("sb_order%0d", k), od[k], sb[k].pop_front());
                end
                if (in_valid && ir[k]) sb[k].push_back(in_data);
                if (flush) sb[k].delete();
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        drive(1'b0, 96'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("reset");
        end
        reset = 1'b1;
        step();
        check_idle("idle");

        // streaming with no back-pressure
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 96'(i), 1'b1, 1'b0);
            step();
            check("stream_data_a", od[0], 96'(i));
            check("stream_valid_a", 96'(ov[0]), 96'd1);
            check("stream_data_b", od[1], 96'(i));
            check("stream_valid_b", 96'(ov[1]), 96'd1);
        end
        drive(1'b0, 96'd0, 1'b1, 1'b0);
        step();
        check("stream_drain_a", 96'(ov[0]), 96'd0);
        check("stream_drain_b", 96'(ov[1]), 96'd0);

        // back-pressure: A1 lands in skid, A2 waits upstream
        drive(1'b1, 96'hA0, 1'b1, 1'b0);
        step();
        check("bp_first", od[0], 96'hA0);
        drive(1'b1, 96'hA1, 1'b0, 1'b0);
        step();
        check("bp_skid_ready", 96'(ir[0]), 96'd0);
        check("bp_hold0", od[0], 96'hA0);
        drive(1'b1, 96'hA2, 1'b0, 1'b0);
        step();
        step();
        check("bp_ready_low", 96'(ir[0]), 96'd0);
        check("bp_hold1", od[0], 96'hA0);
        check("bp_stall_a", 96'(sc_a), 96'd3);
        check("bp_stall_b", 96'(sc_b), 96'd3);
        drive(1'b1, 96'hA2, 1'b1, 1'b0);
        step();
        check("bp_second", od[0], 96'hA1);
        check("bp_ready_back", 96'(ir[0]), 96'd1);
        step();
        check("bp_third", od[0], 96'hA2);
        drive(1'b0, 96'd0, 1'b1, 1'b0);
        step();
        check("bp_drain", 96'(ov[0]), 96'd0);

        // flush while both entries are held
        drive(1'b1, 96'hB0, 1'b0, 1'b0);
        step();
        drive(1'b1, 96'hB1, 1'b0, 1'b0);
        step();
        check("fl_skid_ready", 96'(ir[0]), 96'd0);
        check("fl_head", od[0], 96'hB0);
        drive(1'b1, 96'hB2, 1'b0, 1'b1);
        step();
        drive(1'b0, 96'd0, 1'b1, 1'b0);
        check("fl_valid", 96'(ov[0]), 96'd0);
        check("fl_ready", 96'(ir[0]), 96'd1);
        check("fl_data_cleared", od[0], 96'd0);
        step();
        step();
        check("fl_no_b2", 96'(ov[0]), 96'd0);
        check("fl_stall_a", 96'(sc_a), 96'd5);

        // flush coinciding with both handshakes: C0 leaves, C1 is dropped
        drive(1'b1, 96'hC0, 1'b1, 1'b0);
        step();
        check("flf_head", od[0], 96'hC0);
        drive(1'b1, 96'hC1, 1'b1, 1'b1);
        step();
        drive(1'b0, 96'd0, 1'b1, 1'b0);
        check("flf_valid_a", 96'(ov[0]), 96'd0);
        check("flf_valid_b", 96'(ov[1]), 96'd0);
        step();
        check("flf_still_empty", 96'(ov[0]), 96'd0);

        // stall counter saturation on the 4-bit instance
        drive(1'b1, 96'hD0, 1'b0, 1'b0);
        step();
        drive(1'b0, 96'd0, 1'b0, 1'b0);
        repeat (20) step();
        check("sat_c", 96'(sc_c), 96'd15);
        check("sat_a", 96'(sc_a), 96'd25);
        step();
        check("sat_c_hold", 96'(sc_c), 96'd15);
        check("sat_a_more", 96'(sc_a), 96'd26);
        drive(1'b0, 96'd0, 1'b0, 1'b1);
        step();
        drive(1'b0, 96'd0, 1'b1, 1'b0);
        check("sat_c_flush", 96'(sc_c), 96'd15);
        check("sat_a_flush", 96'(sc_a), 96'd27);
        check("sat_b_flush", 96'(sc_b), 96'd27);
        check("sat_flush_valid", 96'(ov[0]), 96'd0);
        step();
        check("sat_a_idle", 96'(sc_a), 96'd27);

        // asynchronous reset between edges while in the skid state
        drive(1'b1, 96'hE0, 1'b0, 1'b0);
        step();
        drive(1'b1, 96'hE1, 1'b0, 1'b0);
        step();
        check("ar_skid_ready", 96'(ir[0]), 96'd0);
        drive(1'b0, 96'd0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check_idle("ar");
        step();
        reset = 1'b1;
        drive(1'b1, 96'hF0, 1'b1, 1'b0);
        step();
        check("ar_recover", od[0], 96'hF0);
        drive(1'b0, 96'd0, 1'b1, 1'b0);
        step();
        check("ar_drain", 96'(ov[0]), 96'd0);

        step();
        for (int k = 0; k < 3; k++) check($sformatf("sb_left%0d", k), 96'(sb[k].size()), 96'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
